sap_core: RTL
=============

# sap_core

Parametrised successor to the fixed 8-bit SAP-1 datapath: a complete single-bus SAP-class microcomputer in one block, with program counter, memory address register, instruction register, accumulator A, B register, carry/zero flags, output register, internal RAM and a T-state controller. Widths and memory depth are parameters. The instruction set adds store, immediate load and conditional jumps. The block is loaded through a program port while stopped, started with `run`, and reports results through `output_reg`/`out_valid`.

## Interface
- `DATA_W`, default 8: word width of RAM, A, B, IR and output_reg. Must satisfy DATA_W >= 4 + ADDR_W.
- `ADDR_W`, default 4: address width. RAM depth is 2^ADDR_W words.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `run`  in  1  start request; sampled only in IDLE or HALT.
- `prog_we`  in  1  RAM write strobe from the loader; honoured only in IDLE or HALT.
- `prog_addr`  in  ADDR_W  loader write address.
- `prog_data`  in  DATA_W  loader write data.
- `output_reg`  out  DATA_W  output register, loaded by OUT.
- `out_valid`  out  1  one-cycle pulse when output_reg is loaded.
- `halted`  out  1  high in HALT state.
- `busy`  out  1  high in T1..T6.
- `pc`  out  ADDR_W  current program counter.

## Operation
- Instruction word: opcode is bits [DATA_W-1:DATA_W-4]; operand is bits [ADDR_W-1:0]; any bits between are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDA: A<=M[op].
  - 2 ADD: A<=A+M[op].
  - 3 SUB: A<=A-M[op].
  - 4 STA: M[op]<=A.
  - 5 LDI: A<=zero-extended op.
  - 6 JMP: PC<=op.
  - 7 JC: PC<=op if C.
  - 8 JZ: PC<=op if Z.
  - E OUT.
  - F HLT.
  - 9..D execute as NOP.
- States: IDLE, T1..T6, HALT.
  - IDLE/HALT with run=1: PC<=0, go to T1.
  - T1..T5 advance to the next T-state. T6 returns to T1.
  - HLT at T4 goes to HALT.
- Fetch:
  - T1: MAR<=PC.
  - T2: PC<=PC+1, wrapping 2^ADDR_W-1 to 0.
  - T3: IR<=M[MAR].
- Execute:
  - LDA, ADD, SUB, STA at T4: MAR<=op.
  - LDA at T5: A<=M[MAR].
  - ADD/SUB at T5: B<=M[MAR].
  - ADD/SUB at T6: A<=result; C and Z updated.
  - STA at T5: M[MAR]<=A.
  - LDI, JMP, JC, JZ, OUT at T4: act as defined above. OUT also pulses out_valid.
  - Unused T-states do nothing. Every instruction except HLT takes exactly 6 cycles.
- RAM read is combinational on MAR. RAM write is synchronous.
- Arithmetic is modulo 2^DATA_W.
  - ADD: C = carry out.
  - SUB: computed as A + ~B + 1; C = carry out (1 means no borrow, A >= B).
  - Z = (result == 0).
  - Only ADD and SUB touch the flags.
- Loader:
  - prog_we in IDLE/HALT writes M[prog_addr]<=prog_data. In any other state it is ignored.
  - prog_we and run in the same cycle: the write is performed and the start is taken; the first fetch sees the new data.
- Restart from HALT keeps A, B, flags, output_reg and RAM; only PC is cleared.

## Timing
- Reset asserted, asynchronously:
  - state IDLE.
  - PC, MAR, IR, A, B, C, Z, output_reg = 0.
  - out_valid = 0, halted = 0, busy = 0.
  - RAM contents are not reset.
- Reset asserted mid-instruction aborts it immediately. A pending STA write is not performed unless its edge has already occurred.
- Cycle counting: edge E0 samples run=1. The state is T1 after E0. Instruction n occupies the states after E(6n)..E(6n+5).
- OUT in instruction n: output_reg and out_valid=1 after E(6n+4); out_valid=0 after E(6n+5).
- HLT in instruction n: halted=1 and busy=0 after E(6n+4).
- A taken jump at T4 is visible on `pc` after E(6n+4). The next fetch uses it.
- run held high in T1..T6 has no effect.

## Test plan
- **Reset and idle:** assert reset mid-run, then release → all outputs 0; busy=0; halted=0; toggling prog_we while busy never alters RAM.
- **Basic program:** program M0=0x19, M1=0x2A, M2=0xE0, M3=0xF0, M9=0x10, MA=0x14; pulse run at E0 → output_reg=0x24 with out_valid high only after E16; halted=1 after E22.
- **SUB and JZ:** LDI 5; SUB M[8]=0x05; JZ 7; OUT at 7 → A=0x00, Z=1, C=1, jump taken. Repeat with M[8]=0x06 → A=0xFF, C=0, Z=0, JZ falls through.
- **ADD overflow and JC:** A=0xF0 plus M=0x20 → A=0x10, C=1, JC taken. Follow with 0x01+0x01 → C=0, JC not taken.
- **STA and wrap:** LDI 9; STA F; LDA F; OUT at addresses 0..3, NOPs to 0xE, JMP 0 at 0xF → output_reg=0x09. Also confirm PC wraps F→0 when 0xF holds a NOP.
- **Restart and load:** in HALT, rewrite M2 and assert run in the same cycle → PC=0, the new M2 is executed, and A carries over from the previous run.

Source files
------------

// File: rtl/sap_core.sv
// SAP-class single-bus microcomputer: PC, MAR, IR, A, B, C/Z flags, output register,
// internal RAM and a six-T-state controller, with a stopped-state program loader.
module sap_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] output_reg,
  output logic              out_valid,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [3:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic                c;
  logic                z;
  logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

  logic [DATA_W-1:0]   mem_rd;
  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                stopped;
  logic                is_sub;
  logic [DATA_W:0]     sum;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                unused_ir;

  assign mem_rd    = mem[mar];
  assign opcode    = ir[DATA_W-1 -: 4];
  assign operand   = ir[ADDR_W-1:0];
  assign unused_ir = ^ir;
  assign stopped   = (state == S_IDLE) || (state == S_HALT);
  assign halted    = (state == S_HALT);
  assign busy      = !stopped;
  assign is_sub    = (opcode == OP_SUB);

  // SUB is A + ~B + 1, so the carry out doubles as a "no borrow" flag
  always_comb begin
    sum = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + (DATA_W+1)'(is_sub);
  end

  // Loader and STA never coincide: the loader is only honoured while stopped
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (reset && stopped && prog_we) begin
      mem_we = 1'b1;
    end else if (reset && state == S_T5 && opcode == OP_STA) begin
      mem_we    = 1'b1;
      mem_waddr = mar;
      mem_wdata = a;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      c          <= 1'b0;
      z          <= 1'b0;
      output_reg <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            pc    <= '0;
            state <= S_T1;
          end
        end
        S_T1: begin
          mar   <= pc;
          state <= S_T2;
        end
        S_T2: begin
          pc    <= pc + ADDR_W'(1);
          state <= S_T3;
        end
        S_T3: begin
          ir    <= mem_rd;
          state <= S_T4;
        end
        S_T4: begin
          state <= S_T5;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
            OP_LDI: a  <= DATA_W'(operand);
            OP_JMP: pc <= operand;
            OP_JC:  if (c) pc <= operand;
            OP_JZ:  if (z) pc <= operand;
            OP_OUT: begin
              output_reg <= a;
              out_valid  <= 1'b1;
            end
            OP_HLT: state <= S_HALT;
            default: ;
          endcase
        end
        S_T5: begin
          state <= S_T6;
          if (opcode == OP_LDA) begin
            a <= mem_rd;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            b <= mem_rd;
          end
        end
        S_T6: begin
          state <= S_T1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            a <= sum[DATA_W-1:0];
            c <= sum[DATA_W];
            z <= (sum[DATA_W-1:0] == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
